// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline control blocks.
package mips_pkg;

  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_PC8 = 3'b010;
  localparam logic [2:0] WB_HI  = 3'b100;
  localparam logic [2:0] WB_LO  = 3'b101;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_BUSY = 1'b1
  } multState_t;

  // Memory stage wins over Writeback; r0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic       regWriteM,
    input logic [4:0] writeRegM,
    input logic       regWriteW,
    input logic [4:0] writeRegW,
    input logic [4:0] src
  );
    if (regWriteM && writeRegM == src && writeRegM != 5'd0)
      return FWD_M;
    else if (regWriteW && writeRegW == src && writeRegW != 5'd0)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Stage-to-hazard-unit bundle: register specifiers and writeback controls in, pipeline controls out.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic             branchD;
  logic             multstartD;
  logic [2:0]       WBSrcD;
  logic [4:0]       rsE;
  logic [4:0]       rtE;
  logic [4:0]       WriteRegE;
  logic             RegWriteE;
  logic [2:0]       WBSrcE;
  logic             MultStartE;
  logic             MultDoneE;
  logic [4:0]       WriteRegM;
  logic             RegWriteM;
  logic [2:0]       WBSrcM;
  logic [4:0]       WriteRegW;
  logic             RegWriteW;

  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic [1:0]       forwardAD;
  logic [1:0]       forwardBD;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             mult_busy;
  logic             mult_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, branchD, multstartD, WBSrcD,
           rsE, rtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
           WriteRegM, RegWriteM, WBSrcM, WriteRegW, RegWriteW,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           mult_busy, mult_timeout, stall_cycles
  );

  modport slave (
    input  rsD, rtD, branchD, multstartD, WBSrcD,
           rsE, rtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
           WriteRegM, RegWriteM, WBSrcM, WriteRegW, RegWriteW,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
           mult_busy, mult_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_mult.sv
// Multiplier busy tracker: IDLE/BUSY FSM with saturating watchdog and sticky timeout flag.
// Latency: busy registered one cycle after start; done releases in the same cycle.
// Backpressure: none; starts while busy are ignored since Decode is held upstream.
module mult_tracker
  import mips_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic MultStartE,
  input  logic MultDoneE,
  output logic multBusy,
  output logic multTimeout
);

  localparam int              WD_W    = $clog2(MULT_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULT_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  multState_t      state, stateNext;
  logic [WD_W-1:0] wdCnt, wdNext;
  logic            timeoutHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MULT_IDLE;
      wdCnt       <= '0;
      multTimeout <= 1'b0;
    end else begin
      state <= stateNext;
      wdCnt <= wdNext;
      if (timeoutHit)
        multTimeout <= 1'b1;
    end
  end

  always_comb begin
    stateNext  = state;
    wdNext     = wdCnt;
    timeoutHit = 1'b0;
    case (state)
      MULT_IDLE: begin
        if (MultStartE && !MultDoneE) begin
          stateNext = MULT_BUSY;
          wdNext    = '0;
        end
      end
      MULT_BUSY: begin
        if (MultDoneE) begin
          stateNext = MULT_IDLE;
        end else if (wdCnt == WD_LAST) begin
          stateNext  = MULT_IDLE;
          timeoutHit = 1'b1;
        end else if (wdCnt != WD_MAX) begin
          wdNext = wdCnt + 1'b1;
        end
      end
      default: stateNext = MULT_IDLE;
    endcase
  end

  // Busy is masked during reset so the stall path sees IDLE immediately.
  assign multBusy = (state == MULT_BUSY) && !rst;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load/branch/multiply stalls, stall counter.
// Latency: all stall/flush/forward outputs combinational (zero cycles).
// Backpressure: stallF/stallD hold the front end; flushE bubbles Execute.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hu
);

  logic             multBusy;
  logic             multTimeout;
  logic             lwStall;
  logic             branchStall;
  logic             multStall;
  logic             stall;
  logic             hitE;
  logic             hitM;
  logic [CNT_W-1:0] stallCnt;

  mult_tracker #(
    .MULT_TIMEOUT (MULT_TIMEOUT)
  ) u_mult (
    .clk         (clk),
    .rst         (rst),
    .MultStartE  (hu.MultStartE),
    .MultDoneE   (hu.MultDoneE),
    .multBusy    (multBusy),
    .multTimeout (multTimeout)
  );

  always_comb begin
    hitE = hu.WriteRegE != 5'd0 && (hu.WriteRegE == hu.rsD || hu.WriteRegE == hu.rtD);
    hitM = hu.WriteRegM != 5'd0 && (hu.WriteRegM == hu.rsD || hu.WriteRegM == hu.rtD);

    lwStall     = (hu.WBSrcE == WB_MEM) && hitE;
    branchStall = hu.branchD && ((hu.RegWriteE && hitE) || (hu.WBSrcM == WB_MEM && hitM));
    multStall   = multBusy && !hu.MultDoneE &&
                  (hu.multstartD || hu.WBSrcD == WB_HI || hu.WBSrcD == WB_LO);
    stall       = !rst && (lwStall || branchStall || multStall);
  end

  // Decode only takes M-stage forwards; W results arrive via register-file write-through.
  always_comb begin
    hu.forwardAE = FWD_RF;
    hu.forwardBE = FWD_RF;
    hu.forwardAD = FWD_RF;
    hu.forwardBD = FWD_RF;
    if (!rst) begin
      hu.forwardAE = fwdSel(hu.RegWriteM, hu.WriteRegM, hu.RegWriteW, hu.WriteRegW, hu.rsE);
      hu.forwardBE = fwdSel(hu.RegWriteM, hu.WriteRegM, hu.RegWriteW, hu.WriteRegW, hu.rtE);
      hu.forwardAD = fwdSel(hu.RegWriteM, hu.WriteRegM, 1'b0, 5'd0, hu.rsD);
      hu.forwardBD = fwdSel(hu.RegWriteM, hu.WriteRegM, 1'b0, 5'd0, hu.rtD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stallCnt <= '0;
    else if (stall)
      stallCnt <= stallCnt + 1'b1;
  end

  assign hu.stallF       = stall;
  assign hu.stallD       = stall;
  assign hu.flushE       = stall || rst;
  assign hu.mult_busy    = multBusy;
  assign hu.mult_timeout = multTimeout;
  assign hu.stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hazard_unit_if #(.CNT_W(32)) hu ();

  hazard_unit #(
    .MULT_TIMEOUT (8),
    .CNT_W        (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hu  (hu)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit obs=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    hu.rsD = 0; hu.rtD = 0; hu.branchD = 0; hu.multstartD = 0; hu.WBSrcD = WB_ALU;
    hu.rsE = 0; hu.rtE = 0; hu.WriteRegE = 0; hu.RegWriteE = 0; hu.WBSrcE = WB_ALU;
    hu.MultStartE = 0; hu.MultDoneE = 0;
    hu.WriteRegM = 0; hu.RegWriteM = 0; hu.WBSrcM = WB_ALU;
    hu.WriteRegW = 0; hu.RegWriteW = 0;
  endtask

  initial begin
    clearIn();
    rst = 1'b1;
    hu.RegWriteM = 1; hu.WriteRegM = 8; hu.rsE = 8;
    tick(); tick();
    chk("rst_flushE", hu.flushE, 1);
    chk("rst_stallD", hu.stallD, 0);
    chk("rst_stallF", hu.stallF, 0);
    chk("rst_fwdAE", hu.forwardAE, 0);
    chk("rst_busy", hu.mult_busy, 0);
    chk("rst_cnt", hu.stall_cycles, 0);
    chk("rst_tmo", hu.mult_timeout, 0);

    rst = 1'b0;
    hu.RegWriteW = 1; hu.WriteRegW = 8;
    #1;
    chk("fwdAE_M", hu.forwardAE, 2'b10);
    chk("flushE_idle", hu.flushE, 0);
    hu.WriteRegM = 9;
    #1;
    chk("fwdAE_W", hu.forwardAE, 2'b01);
    hu.rsE = 0; hu.WriteRegM = 0; hu.WriteRegW = 0;
    #1;
    chk("fwdAE_r0", hu.forwardAE, 2'b00);
    chk("fwdBE_r0", hu.forwardBE, 2'b00);

    // load-use stall
    clearIn();
    hu.WBSrcE = WB_MEM; hu.WriteRegE = 5; hu.rtD = 5;
    #1;
    chk("lw_stallF", hu.stallF, 1);
    chk("lw_stallD", hu.stallD, 1);
    chk("lw_flushE", hu.flushE, 1);
    tick();
    clearIn();
    hu.WBSrcM = WB_MEM; hu.WriteRegM = 5; hu.rtD = 5;
    hu.rtE = 5; hu.RegWriteW = 1; hu.WriteRegW = 5;
    #1;
    chk("lw_cnt", hu.stall_cycles, 1);
    chk("lw_after_stall", hu.stallD, 0);
    chk("lw_fwdBE_W", hu.forwardBE, 2'b01);

    // branch operand produced in Execute, then forwarded from Memory
    clearIn();
    hu.branchD = 1; hu.RegWriteE = 1; hu.WriteRegE = 3; hu.rsD = 3;
    #1;
    chk("br_stallE", hu.stallD, 1);
    tick();
    hu.RegWriteE = 0; hu.WriteRegE = 0; hu.RegWriteM = 1; hu.WriteRegM = 3;
    #1;
    chk("br_release", hu.stallD, 0);
    chk("br_fwdAD", hu.forwardAD, 2'b10);
    chk("br_fwdBD", hu.forwardBD, 2'b00);
    chk("br_cnt", hu.stall_cycles, 2);

    // branch waiting on a load in Memory
    clearIn();
    hu.branchD = 1; hu.WBSrcM = WB_MEM; hu.WriteRegM = 3; hu.rtD = 3;
    #1;
    chk("br_stallM", hu.stallD, 1);
    tick();
    clearIn();
    #1;
    chk("br_cnt2", hu.stall_cycles, 3);

    // multiply: LO read held until done
    hu.MultStartE = 1;
    #1;
    chk("mul_busy0", hu.mult_busy, 0);
    tick();
    hu.MultStartE = 0; hu.WBSrcD = WB_LO;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mul_stall%0d", i), hu.stallD, 1);
      chk($sformatf("mul_busy%0d", i), hu.mult_busy, 1);
      tick();
    end
    hu.MultDoneE = 1;
    #1;
    chk("mul_done_stall", hu.stallD, 0);
    chk("mul_done_busy", hu.mult_busy, 1);
    tick();
    hu.MultDoneE = 0;
    #1;
    chk("mul_idle", hu.mult_busy, 0);
    chk("mul_idle_stall", hu.stallD, 0);
    chk("mul_cnt", hu.stall_cycles, 7);

    // start and done together never enters BUSY
    clearIn();
    hu.MultStartE = 1; hu.MultDoneE = 1;
    tick();
    clearIn();
    #1;
    chk("mul_same_cycle", hu.mult_busy, 0);

    // watchdog timeout
    hu.MultStartE = 1;
    tick();
    hu.MultStartE = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("tmo_busy%0d", i), hu.mult_busy, 1);
      if (i == 0) begin
        hu.multstartD = 1;
        #1;
        chk("tmo_multstartD", hu.stallD, 1);
      end
      tick();
      hu.multstartD = 0;
    end
    #1;
    chk("tmo_idle", hu.mult_busy, 0);
    chk("tmo_flag", hu.mult_timeout, 1);
    chk("tmo_cnt", hu.stall_cycles, 8);
    tick(); tick();
    chk("tmo_sticky", hu.mult_timeout, 1);

    // reset mid-multiply
    hu.MultStartE = 1;
    tick();
    hu.MultStartE = 0;
    #1;
    chk("rb_busy", hu.mult_busy, 1);
    rst = 1'b1;
    #1;
    chk("rb_busy_comb", hu.mult_busy, 0);
    chk("rb_flushE", hu.flushE, 1);
    tick();
    chk("rb_cnt", hu.stall_cycles, 0);
    chk("rb_tmo", hu.mult_timeout, 0);
    chk("rb_flushE_hold", hu.flushE, 1);
    rst = 1'b0;
    tick();
    chk("rb_idle", hu.mult_busy, 0);
    chk("rb_tmo_after", hu.mult_timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
